// File: rtl/undocumented_register_bank_pkg.sv
//------------------------------------------------------------------------------
// Module  : undoc_reg_pkg
// Purpose : Shared types and constants for the CGB undocumented register bank.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package undoc_reg_pkg;

  typedef enum logic [0:0] {
    LIVE = 1'b0,
    HELD = 1'b1
  } snap_state_t;

  // Register 0 in the LSBs; the top register keeps only bits 6:4 writable.
  localparam logic [31:0] c_SCR_MASK_DEFAULT  = {8'h70, 8'hFF, 8'hFF, 8'hFF};
  localparam logic [31:0] c_SCR_FIXED_DEFAULT = {8'h8F, 8'h00, 8'h00, 8'h00};

  function automatic int pcm_bytes(input int ch, input int w);
    return (ch * w) / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/undocumented_register_bank_pcm_snapshot.sv
//------------------------------------------------------------------------------
// Module  : pcm_snapshot
// Purpose : PCM amplitude input stage with a coherent multi-byte snapshot hold.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pcm_snapshot
  import undoc_reg_pkg::*;
#(
  parameter int PCM_BITS   = 16,
  parameter int HOLD_TICKS = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cpu_en,
  input  logic                cgb,
  input  logic                rd_first,
  input  logic                rd_last,
  input  logic [PCM_BITS-1:0] pcm_amp,
  output logic [PCM_BITS-1:0] pcm_vec
);

  localparam int c_CNT_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_RELOAD = c_CNT_W'(HOLD_TICKS - 1);

  snap_state_t         r_state;
  snap_state_t         w_state_nxt;
  logic [c_CNT_W-1:0]  r_hold_cnt;
  logic [c_CNT_W-1:0]  w_cnt_nxt;
  logic [PCM_BITS-1:0] r_pcm_q;
  logic [PCM_BITS-1:0] r_snap;
  logic [PCM_BITS-1:0] w_snap_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= LIVE;
      r_hold_cnt <= '0;
      r_pcm_q    <= '0;
      r_snap     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_cnt_nxt;
      r_snap     <= w_snap_nxt;
      if (cpu_en) begin
        r_pcm_q <= pcm_amp;
      end
    end
  end

  // A byte-0 read outranks both release conditions; with a single PCM byte
  // the same read also asserts rd_last, so capture and release coincide.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_hold_cnt;
    w_snap_nxt  = r_snap;
    if (cpu_en) begin
      case (r_state)
        LIVE: begin
          if (rd_first) begin
            w_snap_nxt  = r_pcm_q;
            w_cnt_nxt   = c_CNT_RELOAD;
            w_state_nxt = rd_last ? LIVE : HELD;
          end
        end
        HELD: begin
          if (!cgb) begin
            w_state_nxt = LIVE;
          end else if (rd_first) begin
            w_snap_nxt  = r_pcm_q;
            w_cnt_nxt   = c_CNT_RELOAD;
            w_state_nxt = rd_last ? LIVE : HELD;
          end else if (rd_last || (r_hold_cnt == '0)) begin
            w_state_nxt = LIVE;
          end else begin
            w_cnt_nxt = r_hold_cnt - 1'b1;
          end
        end
        default: w_state_nxt = LIVE;
      endcase
    end
  end

  assign pcm_vec = (r_state == HELD) ? r_snap : r_pcm_q;

endmodule

`default_nettype wire

// File: rtl/undocumented_register_bank.sv
//------------------------------------------------------------------------------
// Module  : undocumented_register_bank
// Purpose : CGB-only scratch registers plus a PCM amplitude readback window.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module undocumented_register_bank
  import undoc_reg_pkg::*;
#(
  parameter int                   ADDR_W     = 3,
  parameter int                   SCR_BASE   = 2,
  parameter int                   NUM_SCR    = 4,
  parameter logic [8*NUM_SCR-1:0] SCR_MASK   = c_SCR_MASK_DEFAULT,
  parameter logic [8*NUM_SCR-1:0] SCR_FIXED  = c_SCR_FIXED_DEFAULT,
  parameter int                   PCM_BASE   = 6,
  parameter int                   PCM_CH     = 4,
  parameter int                   PCM_W      = 4,
  parameter int                   HOLD_TICKS = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cpu_en,
  input  logic                      cgb,
  input  logic [ADDR_W-1:0]         reg_select,
  input  logic                      read,
  input  logic                      write,
  input  logic [7:0]                wdata,
  output logic [7:0]                rdata,
  input  logic [PCM_CH*PCM_W-1:0]   pcm_amp
);

  localparam int c_PCM_BITS  = PCM_CH * PCM_W;
  localparam int c_PCM_BYTES = pcm_bytes(PCM_CH, PCM_W);
  localparam int c_WIN       = 1 << ADDR_W;

  generate
    if ((c_PCM_BITS % 8) != 0) begin : g_bad_pcm_width
      $error("PCM_CH*PCM_W must be a multiple of 8");
    end
    if ((SCR_BASE + NUM_SCR > c_WIN) || (PCM_BASE + c_PCM_BYTES > c_WIN)) begin : g_bad_range
      $error("register range exceeds the 2^ADDR_W window");
    end
    if (!((SCR_BASE + NUM_SCR <= PCM_BASE) || (PCM_BASE + c_PCM_BYTES <= SCR_BASE))) begin : g_bad_overlap
      $error("scratch and PCM ranges overlap");
    end
  endgenerate

  logic [7:0]            r_scr [NUM_SCR];
  logic [c_PCM_BITS-1:0] w_pcm_vec;
  logic [7:0]            w_rdata;
  logic                  w_rd_en;
  logic                  w_rd_first;
  logic                  w_rd_last;

  assign w_rd_en    = cpu_en & cgb & read;
  assign w_rd_first = w_rd_en & (reg_select == ADDR_W'(PCM_BASE));
  assign w_rd_last  = w_rd_en & (reg_select == ADDR_W'(PCM_BASE + c_PCM_BYTES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SCR; i++) begin
        r_scr[i] <= '0;
      end
    end else if (cpu_en && cgb && write) begin
      for (int i = 0; i < NUM_SCR; i++) begin
        if (reg_select == ADDR_W'(SCR_BASE + i)) begin
          r_scr[i] <= (r_scr[i] & ~SCR_MASK[8*i +: 8]) | (wdata & SCR_MASK[8*i +: 8]);
        end
      end
    end
  end

  pcm_snapshot #(
    .PCM_BITS   (c_PCM_BITS),
    .HOLD_TICKS (HOLD_TICKS)
  ) u_pcm_snapshot (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_en   (cpu_en),
    .cgb      (cgb),
    .rd_first (w_rd_first),
    .rd_last  (w_rd_last),
    .pcm_amp  (pcm_amp),
    .pcm_vec  (w_pcm_vec)
  );

  // Unmapped indices and all of DMG mode fall through to the open-bus value.
  always_comb begin
    w_rdata = 8'hFF;
    if (cgb) begin
      for (int i = 0; i < NUM_SCR; i++) begin
        if (reg_select == ADDR_W'(SCR_BASE + i)) begin
          w_rdata = (r_scr[i] & SCR_MASK[8*i +: 8]) | (SCR_FIXED[8*i +: 8] & ~SCR_MASK[8*i +: 8]);
        end
      end
      for (int k = 0; k < c_PCM_BYTES; k++) begin
        if (reg_select == ADDR_W'(PCM_BASE + k)) begin
          w_rdata = w_pcm_vec[8*k +: 8];
        end
      end
    end
  end

  assign rdata = w_rdata;

endmodule

`default_nettype wire
